// File: rtl/jk_fsm_bank.sv
// jk_fsm_bank: bank of independent OFF/ON Moore lanes with classic,
// JK-toggle, dwell-gated and hold modes, edge pulses and ON count.
//
// Ports:
//   clk        rising-edge clock
//   areset_n   async active-low reset, clears all state
//   en         per-lane transition enable
//   j / k      per-lane set / clear requests
//   mode       00 classic, 01 JK, 10 dwell-gated, 11 hold
//   min_dwell  dwell value loaded on each transition
//   dout       registered lane state (1 = ON)
//   rise/fall  one-cycle OFF->ON / ON->OFF pulses
//   on_count   number of lanes ON, aligned with dout
module jk_fsm_bank #(
   parameter int CHANNELS = 4,
   parameter int DWELL_W  = 4,
   localparam int CW      = $clog2(CHANNELS + 1)
) (
   input  logic                clk,
   input  logic                areset_n,
   input  logic [CHANNELS-1:0] en,
   input  logic [CHANNELS-1:0] j,
   input  logic [CHANNELS-1:0] k,
   input  logic [1:0]          mode,
   input  logic [DWELL_W-1:0]  min_dwell,
   output logic [CHANNELS-1:0] dout,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CW-1:0]       on_count
);

   typedef enum logic {
      OFF = 1'b0,
      ON  = 1'b1
   } state_t;

   state_t               r_state [CHANNELS];
   logic [DWELL_W-1:0]   r_cnt   [CHANNELS];
   logic [CHANNELS-1:0]  r_rise;
   logic [CHANNELS-1:0]  r_fall;
   logic [CW-1:0]        r_count;

   logic [CHANNELS-1:0]  w_cur;
   logic [CHANNELS-1:0]  w_t;
   logic [CHANNELS-1:0]  w_next;
   logic [CW-1:0]        w_cnt;

   always_comb begin
      w_cur = '0;
      for (int i = 0; i < CHANNELS; i++)
         w_cur[i] = (r_state[i] == ON);
   end

   // Transition request per lane; a request that matches
   // the current state never counts as a transition.
   always_comb begin
      w_t = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (en[i]) begin
            unique case (mode)
               2'b00: w_t[i] = w_cur[i] ? k[i] : j[i];
               2'b01: w_t[i] = w_cur[i] ? k[i] : j[i];
               2'b10: w_t[i] = (r_cnt[i] == '0) &&
                               (w_cur[i] ? k[i] : j[i]);
               default: w_t[i] = 1'b0;
            endcase
         end
      end
   end

   // Count follows the next-state vector so the registered
   // value lines up with dout in the same cycle.
   always_comb begin
      w_next = w_cur ^ w_t;
      w_cnt  = '0;
      for (int i = 0; i < CHANNELS; i++)
         w_cnt = w_cnt + CW'(w_next[i]);
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_state[i] <= OFF;
            r_cnt[i]   <= '0;
         end
         r_rise  <= '0;
         r_fall  <= '0;
         r_count <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (w_t[i]) begin
               r_state[i] <= (r_state[i] == ON) ? OFF : ON;
               r_cnt[i]   <= min_dwell;
            end else if (r_cnt[i] != '0) begin
               r_cnt[i]   <= r_cnt[i] - DWELL_W'(1);
            end
         end
         r_rise  <= w_t & ~w_cur;
         r_fall  <= w_t & w_cur;
         r_count <= w_cnt;
      end
   end

   assign dout     = w_cur;
   assign rise     = r_rise;
   assign fall     = r_fall;
   assign on_count = r_count;

endmodule

// File: doc/jk_fsm_bank.md
# jk_fsm_bank

Parametrised bank of independent two-state (OFF/ON) Moore machines driven by per-channel j/k inputs. Generalises the single set/clear state bit to CHANNELS lanes, adds a selectable JK-toggle mode and a minimum-dwell (anti-chatter) mode, and reports edge pulses and a population count. Sits between raw control/event qualifiers and downstream logic that consumes a stable per-channel ON level.

## Interface
Parameters:
- CHANNELS, 4, number of independent lanes (≥1)
- DWELL_W, 4, width of the minimum-dwell value and the per-lane dwell counters (≥1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- areset_n  in  1  asynchronous, active-low reset; clears all state immediately while low
- en  in  CHANNELS  per-lane transition enable; 0 freezes that lane's state
- j  in  CHANNELS  per-lane set request
- k  in  CHANNELS  per-lane clear request
- mode  in  2  00 classic, 01 JK-toggle, 10 dwell-gated classic, 11 hold
- min_dwell  in  DWELL_W  minimum dwell value, sampled at each transition
- dout  out  CHANNELS  registered lane state, 1 = ON
- rise  out  CHANNELS  one-cycle pulse, high in the first cycle dout[i] reads 1
- fall  out  CHANNELS  one-cycle pulse, high in the first cycle dout[i] reads 0
- on_count  out  $clog2(CHANNELS+1)  number of lanes ON, consistent with dout in the same cycle

## Operation
- Per lane i: state bit S (OFF=0, ON=1), dwell counter C (DWELL_W bits).
- Transition request T per mode (evaluated only when en[i]=1; en[i]=0 → T=0):
  - 00 classic: OFF & j → ON; ON & k → OFF; otherwise hold. k ignored in OFF, j ignored in ON.
  - 01 JK: j&~k → ON; ~j&k → OFF; j&k → toggle; ~j&~k → hold. A request matching the current state is not a transition.
  - 10 dwell-gated: as 00, but blocked while C≠0.
  - 11 hold: no transitions in any lane.
- On a transition: S flips, C loads min_dwell.
- Otherwise: C decrements by 1 if nonzero, saturates at 0. Decrement runs in all modes and regardless of en.
- In mode 10, with min_dwell=D sampled at the transition, dout stays constant for at least D+1 cycles; D=0 gives no gating.
- rise[i] = transition OFF→ON this edge; fall[i] = transition ON→OFF this edge; both registered, never simultaneously high.
- on_count = popcount of the next-state vector, registered, so it always equals popcount(dout).
- Mode changes take effect at the next edge and do not reset counters or state. A counter loaded in mode 00/01 still gates if mode switches to 10 before it expires.

## Timing
- Reset (areset_n=0, asynchronous): dout=0, rise=0, fall=0, on_count=0, all C=0. Release is synchronous to clk; first transition possible at the first rising edge with areset_n=1.
- Latency: input sampled at edge t → dout/rise/fall/on_count valid after edge t (one cycle, Moore).
- rise/fall high for exactly one cycle per transition. Back-to-back transitions (mode 01, j=k=1 held) toggle dout every cycle with alternating rise/fall pulses.
- Reset asserted mid-dwell or mid-pulse clears everything at once; no pulse is emitted for the reset-induced return to OFF.
- All lanes update in the same cycle; on_count covers simultaneous rises and falls in that cycle.

## Test plan
- Reset: drive j=all 1 with areset_n=0 over several edges → dout=0, on_count=0, rise=0. Assert areset_n low asynchronously mid-cycle with dout=4'b1111 → outputs 0 before the next edge, and no fall pulse.
- Classic (mode 00, CHANNELS=4): lane0 j=1 one cycle → dout=4'b0001, rise=4'b0001 for one cycle, on_count=1. Then k=1 with j=1 → dout=4'b0000, fall=4'b0001.
- JK toggle (mode 01): j=k=1 held on lane2 for 4 edges → dout[2] sequence 1,0,1,0 with alternating rise/fall, on_count 1,0,1,0.
- Dwell (mode 10, min_dwell=3): lane1 j pulse at edge 0, k held high from edge 1 → dout[1] ON from edge 0, OFF at edge 4 (stays ON 4 cycles). Repeat with min_dwell=0 → OFF at edge 1.
- Enable/hold: en[3]=0 with j[3]=1 → dout[3] stays 0. mode=11 with all j/k=1 → no change in any lane, and counters still decrement to 0.
- Simultaneous: lanes 0,1 ON; one edge with k on lane0 and j on lanes 2,3 → dout=4'b1110, rise=4'b1100, fall=4'b0001, on_count=3.
